// File: rtl/dsp_share_arbiter_pkg.sv
// Shared constants for the DSP48A1 sharing arbiter: bus widths, field offsets,
// the no-operation opmode and the arbiter state encoding.
package dsp_share_arbiter_pkg;

    localparam int DSP_INS_W  = 92;
    localparam int DSP_OUTS_W = 48;

    // Operand bus layout is {opmode, a, b, c} from MSB down to LSB
    localparam int C_LSB      = 0;
    localparam int C_W        = 48;
    localparam int B_LSB      = 48;
    localparam int B_W        = 18;
    localparam int A_LSB      = 66;
    localparam int A_W        = 18;
    localparam int OPMODE_LSB = 84;
    localparam int OPMODE_W   = 8;

    localparam logic [OPMODE_W-1:0] DSP_NOP = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Latency-matched {valid, idx} shift register that follows each issued DSP op
// so its result can be routed back to the requester that issued it.
module dsp_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             any_valid
);

    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                idx[s] <= '0;
            end
        end else begin
            valid[0] <= in_valid;
            idx[0]   <= in_idx;
            for (int s = 1; s < DEPTH; s++) begin
                valid[s] <= valid[s-1];
                idx[s]   <= idx[s-1];
            end
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];
    assign any_valid = |valid;

endmodule

// File: rtl/dsp_share_arbiter.sv
// Round-robin owner of the shared DSP48A1 slice: grants one requester at a time,
// muxes its operands onto the slice and steers each result back to its issuer.
module dsp_share_arbiter
    import dsp_share_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DSP_LAT = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            lock,
    input  logic [DSP_INS_W*N_REQ-1:0]  req_ins_flat,
    output logic [N_REQ-1:0]            gnt,
    output logic [DSP_INS_W-1:0]        dsp_ins_flat,
    input  logic [DSP_OUTS_W-1:0]       dsp_outs_flat,
    output logic [DSP_OUTS_W-1:0]       res_p,
    output logic [N_REQ-1:0]            res_valid,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] own, own_nxt;
    logic [IDX_W-1:0] rr_ptr, ptr_nxt;
    logic [N_REQ-1:0] others;
    logic             issue;
    logic             tag_valid;
    logic [IDX_W-1:0] tag_idx;
    logic             tags_busy;

    // First candidate at or after start, searching upward with wrap-around
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               j;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(start) + i) % N_REQ;
            if (!found && cand[j]) begin
                pick  = IDX_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            own    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            own    <= own_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    // A released holder hands straight to the next waiting requester, so no idle gap
    always_comb begin
        state_nxt   = state;
        own_nxt     = own;
        ptr_nxt     = rr_ptr;
        others      = req;
        others[own] = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWN;
                    own_nxt   = rr_pick(req, rr_ptr);
                    ptr_nxt   = wrap_inc(own_nxt);
                end
            end
            OWN: begin
                if (!(req[own] || lock[own])) begin
                    if (|others) begin
                        own_nxt = rr_pick(others, rr_ptr);
                        ptr_nxt = wrap_inc(own_nxt);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt          = '0;
        dsp_ins_flat = '0;
        if (state == OWN) begin
            gnt[own]     = 1'b1;
            dsp_ins_flat = req_ins_flat[int'(own)*DSP_INS_W +: DSP_INS_W];
        end
    end

    assign issue = (state == OWN) && (dsp_ins_flat[OPMODE_LSB +: OPMODE_W] != DSP_NOP);

    dsp_tag_pipe #(
        .DEPTH (DSP_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (issue),
        .in_idx    (own),
        .out_valid (tag_valid),
        .out_idx   (tag_idx),
        .any_valid (tags_busy)
    );

    always_comb begin
        res_valid = '0;
        if (tag_valid) begin
            res_valid[tag_idx] = 1'b1;
        end
    end

    assign res_p = dsp_outs_flat;
    assign busy  = (state == OWN) || tags_busy;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Self-checking bench for dsp_share_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of arbitration and results.
module tb_dsp_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int W   = 92;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [W*N-1:0] req_ins_flat = '0;
    logic [47:0]    dsp_outs_flat = '0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   dsp_ins_flat;
    logic [47:0]    res_p;
    logic [N-1:0]   res_valid;
    logic           busy;

    always #5 clk = ~clk;

    dsp_share_arbiter #(
        .N_REQ   (N),
        .DSP_LAT (LAT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .lock          (lock),
        .req_ins_flat  (req_ins_flat),
        .gnt           (gnt),
        .dsp_ins_flat  (dsp_ins_flat),
        .dsp_outs_flat (dsp_outs_flat),
        .res_p         (res_p),
        .res_valid     (res_valid),
        .busy          (busy)
    );

    typedef struct {
        int          due;
        int          idx;
        logic [47:0] p;
    } tag_t;

    tag_t         inflight[$];
    logic [W-1:0] bus [N];
    int           holder;
    int           ptr;
    int           cyc;
    int           n_checks = 0;
    int           n_fail = 0;

    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_ins;
    logic         exp_busy;
    logic [47:0]  exp_p;

    function automatic int pick(input logic [N-1:0] cand, input int start);
        for (int i = 0; i < N; i++) begin
            if (cand[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] make_op(input logic [7:0] opm, input logic [17:0] a,
                                             input logic [17:0] b, input logic [47:0] c);
        return {opm, a, b, c};
    endfunction

    task automatic model_reset();
        holder = -1;
        ptr    = 0;
        cyc    = 0;
        inflight.delete();
    endtask

    task automatic clear_buses();
        for (int k = 0; k < N; k++) bus[k] = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Advances one clock, drives this cycle's inputs, records what the DUT must show
    // during the cycle, then applies the arbitration rules for the following edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l);
        logic [N-1:0] others;
        logic [47:0]  a;
        logic [47:0]  b;
        @(posedge clk);
        #1;
        cyc++;
        req  = r;
        lock = l;
        for (int k = 0; k < N; k++) req_ins_flat[k*W +: W] = bus[k];
        exp_gnt  = '0;
        exp_ins  = '0;
        exp_rv   = '0;
        exp_p    = 48'({$urandom(), $urandom()});
        exp_busy = (holder >= 0) || (inflight.size() > 0);
        if (holder >= 0) begin
            exp_gnt[holder] = 1'b1;
            exp_ins         = bus[holder];
        end
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            exp_rv[inflight[0].idx] = 1'b1;
            exp_p = inflight[0].p;
            void'(inflight.pop_front());
        end
        dsp_outs_flat = exp_p;
        if (holder >= 0 && bus[holder][91:84] != 8'h00) begin
            a = 48'(bus[holder][83:66]);
            b = 48'(bus[holder][65:48]);
            inflight.push_back(tag_t'{cyc + LAT, holder, a * b});
        end
        if (holder < 0) begin
            if (r != '0) begin
                holder = pick(r, ptr);
                ptr    = (holder + 1) % N;
            end
        end else if (!r[holder] && !l[holder]) begin
            others         = r;
            others[holder] = 1'b0;
            if (others != '0) begin
                holder = pick(others, ptr);
                ptr    = (holder + 1) % N;
            end else begin
                holder = -1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        lock    = '0;
        for (int k = 0; k < N; k++) begin
            bus[k] = make_op(8'h05, 18'($urandom), 18'($urandom), 48'({$urandom(), $urandom()}));
            req_ins_flat[k*W +: W] = bus[k];
        end
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (gnt !== '0) begin n_fail++; $display("[TB] FAIL reset_gnt got=%b want=0", gnt); end
        n_checks++;
        if (dsp_ins_flat !== '0) begin n_fail++; $display("[TB] FAIL reset_ins got=%h want=0", dsp_ins_flat); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        n_checks++;
        if (res_valid !== '0) begin n_fail++; $display("[TB] FAIL reset_res_valid got=%b want=0", res_valid); end
        clear_buses();
        do_reset();
    endtask

    task automatic test_single_requester();
        logic [N-1:0] rs     [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [N-1:0] want_g [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [N-1:0] want_v [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        clear_buses();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus[2] = (c == 1) ? make_op(8'h01, 18'h10000, 18'h08000, 48'h0) : '0;
            applyStimulus(rs[c], '0);
            n_checks++;
            if (gnt !== want_g[c]) begin n_fail++; $display("[TB] FAIL single_gnt c=%0d got=%b want=%b", c, gnt, want_g[c]); end
            n_checks++;
            if (res_valid !== want_v[c]) begin n_fail++; $display("[TB] FAIL single_res_valid c=%0d got=%b want=%b", c, res_valid, want_v[c]); end
            if (c == 1) begin
                n_checks++;
                if (dsp_ins_flat !== bus[2]) begin n_fail++; $display("[TB] FAIL single_ins got=%h want=%h", dsp_ins_flat, bus[2]); end
            end
            if (c == 4) begin
                n_checks++;
                if (res_p !== 48'h0_8000_0000) begin n_fail++; $display("[TB] FAIL single_res_p got=%h want=%h", res_p, 48'h0_8000_0000); end
            end
        end
    endtask

    task automatic test_contention();
        int           cnt = 0;
        int           prev = -1;
        int           order[$];
        int           want_order [4] = '{0, 1, 3, 0};
        logic [N-1:0] last_g = '0;
        logic [N-1:0] r;
        clear_buses();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            r = 4'b1011;
            if (holder >= 0) begin
                cnt  = (holder == prev) ? cnt + 1 : 1;
                prev = holder;
                if (cnt >= 3) r[holder] = 1'b0;
            end
            applyStimulus(r, '0);
            n_checks++;
            if (gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL contention_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt); end
            if (last_g != '0) begin
                n_checks++;
                if (gnt === '0) begin n_fail++; $display("[TB] FAIL contention_gap c=%0d got=%b want=nonzero", c, gnt); end
            end
            if (gnt != '0 && gnt != last_g) order.push_back(onehot_idx(gnt));
            last_g = gnt;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (order.size() <= i) begin
                n_fail++;
                $display("[TB] FAIL contention_order i=%0d got=none want=%0d", i, want_order[i]);
            end else if (order[i] != want_order[i]) begin
                n_fail++;
                $display("[TB] FAIL contention_order i=%0d got=%0d want=%0d", i, order[i], want_order[i]);
            end
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] rs     [7] = '{4'b0010, 4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [N-1:0] ls     [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [N-1:0] want_g [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        clear_buses();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(rs[c], ls[c]);
            n_checks++;
            if (gnt !== want_g[c]) begin n_fail++; $display("[TB] FAIL lock_gnt c=%0d got=%b want=%b", c, gnt, want_g[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] rs     [9] = '{4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic         op0    [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        logic         op3    [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [N-1:0] want_v [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0000};
        clear_buses();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            bus[0] = op0[c] ? make_op(8'h01, 18'($urandom), 18'($urandom), 48'h0) : '0;
            bus[3] = op3[c] ? make_op(8'h03, 18'($urandom), 18'($urandom), 48'h0) : '0;
            applyStimulus(rs[c], '0);
            n_checks++;
            if (res_valid !== want_v[c]) begin n_fail++; $display("[TB] FAIL handoff_res_valid c=%0d got=%b want=%b", c, res_valid, want_v[c]); end
            if (want_v[c] != '0) begin
                n_checks++;
                if (res_p !== exp_p) begin n_fail++; $display("[TB] FAIL handoff_res_p c=%0d got=%h want=%h", c, res_p, exp_p); end
            end
            if (c == 4) begin
                n_checks++;
                if (gnt !== 4'b1000) begin n_fail++; $display("[TB] FAIL handoff_gnt got=%b want=1000", gnt); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_buses();
        do_reset();
        applyStimulus(4'b0001, '0);
        bus[0] = make_op(8'h01, 18'h00123, 18'h00456, 48'h0);
        applyStimulus(4'b0001, '0);
        bus[0] = '0;
        applyStimulus(4'b0000, '0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midflight_busy_before got=%b want=1", busy); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0) begin n_fail++; $display("[TB] FAIL midflight_gnt got=%b want=0", gnt); end
        n_checks++;
        if (res_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midflight_async got res_valid=%b busy=%b want 0/0", res_valid, busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            applyStimulus('0, '0);
            n_checks++;
            if (res_valid !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midflight_after c=%0d got res_valid=%b busy=%b want 0/0", c, res_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] l;
        clear_buses();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                bus[k] = make_op(($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                                 18'($urandom), 18'($urandom), 48'({$urandom(), $urandom()}));
            end
            r = N'($urandom);
            l = N'($urandom & $urandom & $urandom);
            applyStimulus(r, l);
            n_checks++;
            if (gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL rand_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt); end
            n_checks++;
            if (dsp_ins_flat !== exp_ins) begin n_fail++; $display("[TB] FAIL rand_ins c=%0d got=%h want=%h", c, dsp_ins_flat, exp_ins); end
            n_checks++;
            if (res_valid !== exp_rv) begin n_fail++; $display("[TB] FAIL rand_res_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            n_checks++;
            if (busy !== exp_busy) begin n_fail++; $display("[TB] FAIL rand_busy c=%0d got=%b want=%b", c, busy, exp_busy); end
            n_checks++;
            if (res_p !== exp_p) begin n_fail++; $display("[TB] FAIL rand_res_p c=%0d got=%h want=%h", c, res_p, exp_p); end
        end
    endtask

    initial begin
        model_reset();
        clear_buses();
        test_reset();
        test_single_requester();
        test_contention();
        test_lock();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
